// File: rtl/cost_pack_8.sv
// Purpose : packs up to eight per-slot cost beats into one wide vector and pads short vectors with max cost.
// Latency : m_valid rises one cycle after the beat that closes a vector.
// Backpr. : accepts freely while filling; while holding, s_ready follows m_ready so a handoff and a new slot-0 write share a cycle.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   s_valid/s_ready    upstream beat handshake
//   s_cost             cost for the current slot
//   s_last             beat is the last of the vector
//   m_valid/m_ready    downstream vector handshake
//   m_words            packed vector, slot k at [WIDTH*k +: WIDTH]
//   m_error            vector length error, qualified by m_valid
module cost_pack_8 #(
    parameter int WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_cost,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [8*WIDTH-1:0]   m_words,
    output logic                 m_error
);

    localparam int INPUTS     = 8;
    localparam int INDEX_BITS = 3;

    if (WIDTH <= 0) begin : g_bad_width
        $error("cost_pack_8: WIDTH must be positive");
    end

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [INDEX_BITS-1:0]     cnt_q, cnt_d;
    logic [INPUTS*WIDTH-1:0]   words_q, words_d;
    logic                      err_q, err_d;
    logic                      accept;
    logic                      close;
    logic                      cnt_is_last;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        words_d     = words_q;
        err_d       = err_q;

        m_valid     = (state_q == HOLD);
        // In HOLD the slot-0 register is free the moment the vector is taken,
        // so the upstream may advance in the same cycle as the handoff.
        s_ready     = (state_q == FILL) ? 1'b1 : m_ready;
        accept      = s_valid && s_ready;
        cnt_is_last = (cnt_q == INDEX_BITS'(INPUTS - 1));
        close       = accept && (s_last || cnt_is_last);

        if (state_q == HOLD && m_ready) begin
            state_d = FILL;
        end

        if (accept) begin
            // cnt_q is always 0 in HOLD, so a handoff-cycle beat lands in slot 0.
            for (int k = 0; k < INPUTS; k++) begin
                if (INDEX_BITS'(k) == cnt_q) begin
                    words_d[k*WIDTH +: WIDTH] = s_cost;
                end else if (close && (INDEX_BITS'(k) > cnt_q)) begin
                    words_d[k*WIDTH +: WIDTH] = {WIDTH{1'b1}};
                end
            end

            if (close) begin
                cnt_d   = '0;
                state_d = HOLD;
                // Short vector with s_last, or full vector missing s_last.
                err_d   = (s_last && !cnt_is_last) || (cnt_is_last && !s_last);
            end else begin
                cnt_d   = cnt_q + INDEX_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            err_q   <= err_d;
        end
    end

    assign m_words = words_q;
    assign m_error = err_q;

endmodule

// File: tb/tb_cost_pack_8.sv
// Purpose : randomized and directed bench for cost_pack_8 against a queue-based model.
// Latency : checks outputs 1 time unit after each rising edge, s_ready just before it.
// Backpr. : m_ready is driven by the bench (random or directed).
module tb_cost_pack_8;

    localparam int W = 2;

    logic           clk;
    logic           rst_n;
    logic           s_valid;
    logic           s_ready;
    logic [W-1:0]   s_cost;
    logic           s_last;
    logic           m_valid;
    logic           m_ready;
    logic [8*W-1:0] m_words;
    logic           m_error;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pending output vector plus the list of costs collected so far.
    bit             pend_vld;
    logic [8*W-1:0] pend_words;
    bit             pend_err;
    int             part[$];
    int             handoffs;

    cost_pack_8 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_cost  (s_cost),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_words (m_words),
        .m_error (m_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend_vld   = 1'b0;
        pend_words = '0;
        pend_err   = 1'b0;
        part.delete();
    endtask

    // One clock cycle: drive, check s_ready, advance model, check outputs after the edge.
    task automatic cycle(input bit v, input int cost, input bit last, input bit mr);
        bit acc;
        s_valid = v;
        s_cost  = W'(cost);
        s_last  = last;
        m_ready = mr;
        #1;
        chk("s_ready", s_ready, !pend_vld || mr);
        if (m_valid && mr) handoffs++;
        acc = v && (!pend_vld || mr);
        if (pend_vld && mr) pend_vld = 1'b0;
        if (acc) begin
            part.push_back(cost);
            if (part.size() == 8 || last) begin
                for (int i = 0; i < 8; i++)
                    pend_words[i*W +: W] = (i < part.size()) ? W'(part[i]) : {W{1'b1}};
                pend_err = (part.size() < 8) || !last;
                pend_vld = 1'b1;
                part.delete();
            end
        end
        @(posedge clk);
        #1;
        chk("m_valid", m_valid, pend_vld);
        if (pend_vld) begin
            chk("m_words", m_words, pend_words);
            chk("m_error", m_error, pend_err);
        end
    endtask

    initial begin
        int c31[8];
        c31 = '{3, 2, 1, 0, 1, 2, 3, 3};
        s_valid = 0; s_cost = 0; s_last = 0; m_ready = 0;
        handoffs = 0;
        model_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_m_words", m_words, 16'h0);
        chk("rst_m_error", m_error, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full vector with s_last on beat 8.
        for (int i = 0; i < 8; i++) cycle(1, c31[i], i == 7, 0);
        chk("v31_valid", m_valid, 1'b1);
        chk("v31_words", m_words, 16'hF91B);
        chk("v31_error", m_error, 1'b0);
        cycle(0, 0, 0, 1);
        chk("v31_taken", m_valid, 1'b0);

        // Short vector 0,1,2.
        for (int i = 0; i < 3; i++) cycle(1, i, i == 2, 0);
        chk("v32_words", m_words, 16'hFFE4);
        chk("v32_error", m_error, 1'b1);
        cycle(0, 0, 0, 1);

        // Eight beats with no s_last, then next beat is slot 0.
        for (int i = 0; i < 8; i++) cycle(1, i % 4, 0, 0);
        chk("v33_error", m_error, 1'b1);
        chk("v33_words", m_words, 16'hE4E4);
        cycle(1, 1, 1, 1);
        chk("v33_next", m_words, 16'hFFFD);

        // Stall 5 cycles in HOLD, then stream.
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) cycle(1, 3 - (i % 4), i == 7, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0, 0);
            chk("stall_words", m_words, 16'h1B1B);
        end
        handoffs = 0;
        for (int i = 0; i < 24; i++) cycle(1, i % 4, (i % 8) == 7, 1);
        chk("stream_handoffs", handoffs, 3);

        // Single-beat vector on a handoff cycle.
        cycle(1, 2, 1, 1);
        chk("v35_valid", m_valid, 1'b1);
        chk("v35_words", m_words, 16'hFFFE);
        chk("v35_error", m_error, 1'b1);
        cycle(0, 0, 0, 1);

        // Reset after 3 accepted beats.
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", m_valid, 1'b0);
        chk("mid_rst_ready", s_ready, 1'b1);
        chk("mid_rst_words", m_words, 16'h0);
        chk("mid_rst_error", m_error, 1'b0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) cycle(1, c31[i], i == 7, 0);
        chk("v36_words", m_words, 16'hF91B);
        chk("v36_error", m_error, 1'b0);
        cycle(0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
